segment_assembler: RTL and testbench

Upstream stage of the clock-segment generator. Collects 16-bit words from the host pipe (okPipeIn ep80) and packs each group of eight into one 128-bit segment record {on_counts[47:0], off_counts[47:0], repeat_counts[31:0]}. Each completed record is written into the segment FIFO's write port. Runs entirely in the host-interface clock domain; the FIFO performs the crossing to refclk.

---
 rtl/segment_pkg.sv | 21 ++
 rtl/segment_check.sv | 16 +
 rtl/segment_assembler.sv | 147 ++++++++++++++
 tb/tb_segment_assembler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/segment_pkg.sv
// segment_pkg: shared layout of the 128-bit clock-segment record.
// Used by the assembler (host side) and the segment generator (refclk side).
package segment_pkg;

    localparam int IN_W          = 16;
    localparam int SEG_W         = 128;
    localparam int WORDS_PER_SEG = SEG_W / IN_W;

    // Record layout: {on_counts, off_counts, repeat_counts}
    localparam int ON_MSB  = 127;
    localparam int ON_LSB  = 80;
    localparam int OFF_MSB = 79;
    localparam int OFF_LSB = 32;
    localparam int REP_MSB = 31;
    localparam int REP_LSB = 0;

    localparam int ON_W  = ON_MSB - ON_LSB + 1;
    localparam int OFF_W = OFF_MSB - OFF_LSB + 1;
    localparam int REP_W = REP_MSB - REP_LSB + 1;

endpackage

// File: rtl/segment_check.sv
// segment_check: combinational sanity check of a completed segment record.
// A record is usable only if both on_counts and repeat_counts are non-zero.
module segment_check
    import segment_pkg::*;
(
    input  logic [SEG_W-1:0] rec,
    output logic             valid
);

    // off_counts may legitimately be zero, so it takes no part in the check.
    logic unused_off;

    assign unused_off = ^rec[OFF_MSB:OFF_LSB];
    assign valid      = (|rec[ON_MSB:ON_LSB]) && (|rec[REP_MSB:REP_LSB]);

endmodule

// File: rtl/segment_assembler.sv
// segment_assembler: packs eight 16-bit host pipe words into one 128-bit
// segment record and hands it to the segment FIFO through a one-deep
// holding register. No backpressure exists upstream, so a record that
// cannot be held is dropped and counted.
// Optional build macro SEGMENT_ASSEMBLER_CHECK_EN: reject records with
// on_counts==0 or repeat_counts==0 (err_invalid); otherwise err_invalid=0.
module segment_assembler #(
    parameter int IN_W  = segment_pkg::IN_W,
    parameter int SEG_W = segment_pkg::SEG_W,
    parameter int CNT_W = 16
) (
    input  logic             ti_clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [SEG_W-1:0] fifo_din,
    output logic [2:0]       word_idx,
    output logic [CNT_W-1:0] seg_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             err_overflow,
    output logic             err_invalid
);

    localparam int         WORDS    = SEG_W / IN_W;
    localparam logic [2:0] LAST_IDX = 3'(WORDS - 1);

    logic [SEG_W-1:0] asm_q, asm_d;
    logic [SEG_W-1:0] hold_q, hold_d;
    logic             pend_q, pend_d;
    logic [2:0]       word_idx_q, word_idx_d;
    logic [CNT_W-1:0] seg_cnt_q, seg_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             err_ovf_q, err_ovf_d;

    logic             take;
    logic             complete;
    logic             wr_fire;
    logic             accept;
    logic             ovf_drop;
    logic             inv_drop;
    logic             rec_ok;
    logic [SEG_W-1:0] record;

    // The last word is the least-significant one, so the finished record is
    // the assembly register with its bottom slot replaced by the live word.
    assign record = {asm_q[SEG_W-1:IN_W], in_data};

`ifdef SEGMENT_ASSEMBLER_CHECK_EN
    logic err_inv_q, err_inv_d;

    segment_check u_check (
        .rec   (record),
        .valid (rec_ok)
    );

    // Sticky invalid flag, set whenever a completed record is rejected.
    always_comb begin
        err_inv_d = err_inv_q | inv_drop;
    end

    // Invalid-flag register; only reset clears it.
    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) err_inv_q <= 1'b0;
        else       err_inv_q <= err_inv_d;
    end

    assign err_invalid = err_inv_q;
`else
    assign rec_ok      = 1'b1;
    assign err_invalid = 1'b0;
`endif

    // Word packing, record hand-off to the holding register, counters.
    always_comb begin
        take     = in_valid & ~clear;
        complete = take & (word_idx_q == LAST_IDX);
        wr_fire  = pend_q & ~fifo_full;
        // A holding register draining on this edge frees space for the new record.
        accept   = complete & rec_ok & (~pend_q | wr_fire);
        ovf_drop = complete & rec_ok & ~accept;
        inv_drop = complete & ~rec_ok;

        asm_d = asm_q;
        if (take) begin
            asm_d[SEG_W-1-IN_W*int'(word_idx_q) -: IN_W] = in_data;
        end

        word_idx_d = word_idx_q;
        if (clear) begin
            word_idx_d = 3'd0;
        end else if (take) begin
            word_idx_d = complete ? 3'd0 : word_idx_q + 3'd1;
        end

        hold_d = accept ? record : hold_q;

        pend_d = pend_q;
        if (clear) begin
            pend_d = 1'b0;
        end else if (accept) begin
            pend_d = 1'b1;
        end else if (wr_fire) begin
            pend_d = 1'b0;
        end

        seg_cnt_d = seg_cnt_q + CNT_W'(wr_fire);

        drop_cnt_d = drop_cnt_q;
        if ((ovf_drop | inv_drop) && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end

        err_ovf_d = err_ovf_q | ovf_drop;
    end

    // State registers; everything returns to zero on reset.
    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            asm_q      <= '0;
            hold_q     <= '0;
            pend_q     <= 1'b0;
            word_idx_q <= 3'd0;
            seg_cnt_q  <= '0;
            drop_cnt_q <= '0;
            err_ovf_q  <= 1'b0;
        end else begin
            asm_q      <= asm_d;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
            word_idx_q <= word_idx_d;
            seg_cnt_q  <= seg_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

    assign fifo_wr_en   = pend_q & ~fifo_full;
    assign fifo_din     = hold_q;
    assign word_idx     = word_idx_q;
    assign seg_count    = seg_cnt_q;
    assign drop_count   = drop_cnt_q;
    assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_segment_assembler.sv
// tb_segment_assembler: directed table-driven bench plus hand-written
// multi-cycle sequences for overflow, reset, invalid and same-edge drain.
module tb_segment_assembler;

    logic         ti_clk = 1'b0;
    logic         reset;
    logic         clear;
    logic         in_valid;
    logic [15:0]  in_data;
    logic         fifo_full;
    logic         fifo_wr_en;
    logic [127:0] fifo_din;
    logic [2:0]   word_idx;
    logic [15:0]  seg_count;
    logic [15:0]  drop_count;
    logic         err_overflow;
    logic         err_invalid;

    int errors = 0;
    int checks = 0;

    segment_assembler dut (
        .ti_clk       (ti_clk),
        .reset        (reset),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_din     (fifo_din),
        .word_idx     (word_idx),
        .seg_count    (seg_count),
        .drop_count   (drop_count),
        .err_overflow (err_overflow),
        .err_invalid  (err_invalid)
    );

    always #5 ti_clk = ~ti_clk;

    typedef struct {
        logic         v;
        logic [15:0]  d;
        logic         full;
        logic         clr;
        logic         exp_wr;
        logic [2:0]   exp_idx;
        logic [15:0]  exp_seg;
        logic [15:0]  exp_drop;
        logic         chk_din;
        logic [127:0] exp_din;
    } vec_t;

    vec_t vecs[26];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; checks that follow see
    // the state produced by earlier rising edges.
    task automatic drive(input logic v, input logic [15:0] d, input logic f, input logic c);
        @(negedge ti_clk);
        in_valid  = v;
        in_data   = d;
        fifo_full = f;
        clear     = c;
        #1;
    endtask

    task automatic send_rec(input logic [127:0] r, input logic f);
        for (int k = 0; k < 8; k++) drive(1'b1, r[127-16*k -: 16], f, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge ti_clk);
        in_valid = 0; in_data = 0; fifo_full = 0; clear = 0;
        reset = 1'b1;
        @(negedge ti_clk);
        reset = 1'b0;
    endtask

    task automatic set_vec(input int i, input logic v, input logic [15:0] d, input logic clr,
                           input logic wr, input logic [2:0] idx, input logic [15:0] seg,
                           input logic cd, input logic [127:0] din);
        vecs[i].v        = v;
        vecs[i].d        = d;
        vecs[i].full     = 1'b0;
        vecs[i].clr      = clr;
        vecs[i].exp_wr   = wr;
        vecs[i].exp_idx  = idx;
        vecs[i].exp_seg  = seg;
        vecs[i].exp_drop = 16'd0;
        vecs[i].chk_din  = cd;
        vecs[i].exp_din  = din;
    endtask

    logic [127:0] r1, r2, r3, rec_basic, rec_clr, rec_inv;
    logic [15:0]  basic_words[8];

    initial begin
        reset = 1'b1; clear = 0; in_valid = 0; in_data = 0; fifo_full = 0;
        basic_words = '{16'h0000, 16'h0000, 16'h0005, 16'h0000,
                        16'h0000, 16'h000A, 16'h0000, 16'h0003};
        rec_basic = 128'h0000_0000_0005_0000_0000_000A_0000_0003;
        rec_clr   = 128'h0101_0202_0303_0404_0505_0606_0707_0808;
        rec_inv   = 128'h0001_0000_0000_0000_0000_0000_0000_0000;
        r1        = 128'h0011_0000_0000_0000_0000_0000_0000_0001;
        r2        = 128'h0022_0000_0000_0000_0000_0000_0000_0002;
        r3        = 128'h0033_0000_0000_0000_0000_0000_0000_0003;

        // Vector table: basic record, then partial record + clear + full record.
        for (int i = 0; i < 8; i++)
            set_vec(i, 1'b1, basic_words[i], 1'b0, 1'b0, 3'(i), 16'd0, 1'b0, 128'd0);
        set_vec(8, 1'b0, 16'd0, 1'b0, 1'b1, 3'd0, 16'd0, 1'b1, rec_basic);
        set_vec(9, 1'b0, 16'd0, 1'b0, 1'b0, 3'd0, 16'd1, 1'b1, rec_basic);
        for (int i = 0; i < 5; i++)
            set_vec(10 + i, 1'b1, 16'h1111 * 16'(i + 1), 1'b0, 1'b0, 3'(i), 16'd1, 1'b0, 128'd0);
        set_vec(15, 1'b1, 16'hDEAD, 1'b1, 1'b0, 3'd5, 16'd1, 1'b0, 128'd0);
        for (int i = 0; i < 8; i++)
            set_vec(16 + i, 1'b1, 16'h0101 * 16'(i + 1), 1'b0, 1'b0, 3'(i), 16'd1, 1'b0, 128'd0);
        set_vec(24, 1'b0, 16'd0, 1'b0, 1'b1, 3'd0, 16'd1, 1'b1, rec_clr);
        set_vec(25, 1'b0, 16'd0, 1'b0, 1'b0, 3'd0, 16'd2, 1'b1, rec_clr);

        // Reset state
        repeat (2) @(negedge ti_clk);
        chk("rst_wr_en", 128'(fifo_wr_en), 128'd0);
        chk("rst_din", fifo_din, 128'd0);
        chk("rst_idx", 128'(word_idx), 128'd0);
        chk("rst_seg", 128'(seg_count), 128'd0);
        chk("rst_drop", 128'(drop_count), 128'd0);
        chk("rst_ovf", 128'(err_overflow), 128'd0);
        chk("rst_inv", 128'(err_invalid), 128'd0);
        reset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].full, vecs[i].clr);
            chk($sformatf("vec%0d_wr_en", i), 128'(fifo_wr_en), 128'(vecs[i].exp_wr));
            chk($sformatf("vec%0d_idx", i), 128'(word_idx), 128'(vecs[i].exp_idx));
            chk($sformatf("vec%0d_seg", i), 128'(seg_count), 128'(vecs[i].exp_seg));
            chk($sformatf("vec%0d_drop", i), 128'(drop_count), 128'(vecs[i].exp_drop));
            if (vecs[i].chk_din) chk($sformatf("vec%0d_din", i), fifo_din, vecs[i].exp_din);
        end

        // Overflow: three records while full
        do_reset();
        send_rec(r1, 1'b1);
        send_rec(r2, 1'b1);
        drive(1'b0, 16'd0, 1'b1, 1'b0);
        chk("ovf_din_held1", fifo_din, r1);
        chk("ovf_drop1", 128'(drop_count), 128'd1);
        chk("ovf_wr_blocked", 128'(fifo_wr_en), 128'd0);
        send_rec(r3, 1'b1);
        drive(1'b0, 16'd0, 1'b1, 1'b0);
        chk("ovf_din_held2", fifo_din, r1);
        chk("ovf_drop2", 128'(drop_count), 128'd2);
        chk("ovf_flag", 128'(err_overflow), 128'd1);
        chk("ovf_seg0", 128'(seg_count), 128'd0);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        chk("ovf_release_wr", 128'(fifo_wr_en), 128'd1);
        chk("ovf_release_din", fifo_din, r1);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        chk("ovf_after_wr", 128'(fifo_wr_en), 128'd0);
        chk("ovf_seg1", 128'(seg_count), 128'd1);
        chk("ovf_flag_sticky", 128'(err_overflow), 128'd1);

        // Record with repeat_counts == 0
        do_reset();
        send_rec(rec_inv, 1'b0);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
`ifdef SEGMENT_ASSEMBLER_CHECK_EN
        chk("inv_no_wr", 128'(fifo_wr_en), 128'd0);
        chk("inv_flag", 128'(err_invalid), 128'd1);
        chk("inv_drop", 128'(drop_count), 128'd1);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        chk("inv_seg", 128'(seg_count), 128'd0);
        chk("inv_ovf_clear", 128'(err_overflow), 128'd0);
`else
        chk("inv_wr", 128'(fifo_wr_en), 128'd1);
        chk("inv_din", fifo_din, rec_inv);
        chk("inv_flag", 128'(err_invalid), 128'd0);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        chk("inv_seg", 128'(seg_count), 128'd1);
        chk("inv_drop", 128'(drop_count), 128'd0);
`endif

        // Reset mid-record with pend set
        do_reset();
        send_rec(r1, 1'b1);
        for (int k = 0; k < 4; k++) drive(1'b1, r2[127-16*k -: 16], 1'b1, 1'b0);
        drive(1'b0, 16'd0, 1'b1, 1'b0);
        chk("mid_idx4", 128'(word_idx), 128'd4);
        chk("mid_din", fifo_din, r1);
        reset = 1'b1;
        fifo_full = 1'b0;
        #1;
        chk("mid_rst_wr", 128'(fifo_wr_en), 128'd0);
        chk("mid_rst_din", fifo_din, 128'd0);
        chk("mid_rst_idx", 128'(word_idx), 128'd0);
        chk("mid_rst_seg", 128'(seg_count), 128'd0);
        @(negedge ti_clk);
        reset = 1'b0;
        send_rec(r3, 1'b0);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        chk("mid_post_wr", 128'(fifo_wr_en), 128'd1);
        chk("mid_post_din", fifo_din, r3);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        chk("mid_post_seg", 128'(seg_count), 128'd1);

        // Drain and completion on the same edge
        do_reset();
        send_rec(r1, 1'b1);
        for (int k = 0; k < 7; k++) drive(1'b1, r2[127-16*k -: 16], 1'b1, 1'b0);
        drive(1'b1, r2[15:0], 1'b0, 1'b0);
        chk("same_wr1", 128'(fifo_wr_en), 128'd1);
        chk("same_din1", fifo_din, r1);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        chk("same_wr2", 128'(fifo_wr_en), 128'd1);
        chk("same_din2", fifo_din, r2);
        chk("same_seg1", 128'(seg_count), 128'd1);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        chk("same_idle", 128'(fifo_wr_en), 128'd0);
        chk("same_seg2", 128'(seg_count), 128'd2);
        chk("same_drop0", 128'(drop_count), 128'd0);
        chk("same_ovf0", 128'(err_overflow), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
